// File: rtl/lift5_pkg.sv
// Shared constants for the five-floor lift: floor codes, travel direction,
// and the request-latch state encoding.
package lift5_pkg;

  localparam int NFLOORS = 5;

  localparam logic [2:0] FL_A = 3'd0;
  localparam logic [2:0] FL_B = 3'd1;
  localparam logic [2:0] FL_C = 3'd2;
  localparam logic [2:0] FL_D = 3'd3;
  localparam logic [2:0] FL_E = 3'd4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  // Codes 5..7 can appear on the floor bus but name no floor.
  function automatic logic floor_valid(input logic [2:0] f);
    return (f <= FL_E);
  endfunction

endpackage

// File: rtl/lift5_dwell_timer.sv
// Door dwell down-counter: load sets DWELL-1, otherwise counts down to 0 and holds.
// cnt_zero is combinational from the count register; no backpressure.
module lift5_dwell_timer
  import lift5_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic cnt_zero
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/lift5_req_latch.sv
// Latches call-button presses as level requests and clears each after the car has dwelt DWELL cycles at that floor.
// Requests visible one cycle after the press; the current floor's request is held through dwell to pin the car.
module lift5_req_latch
  import lift5_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic [2:0] floor,
  output logic       ra,
  output logic       rb,
  output logic       rc,
  output logic       rd,
  output logic       re,
  output logic       door_open,
  output logic [2:0] svc_floor
);

  logic [NFLOORS-1:0] req;
  logic [NFLOORS-1:0] req_nxt;
  logic [NFLOORS-1:0] btn_q;
  logic [NFLOORS-1:0] press;
  logic [NFLOORS-1:0] clr;
  state_t             state;
  state_t             state_nxt;
  logic               door_nxt;
  logic [2:0]         svc_nxt;
  logic               load;
  logic               cnt_zero;
  logic               floor_req;

  assign press     = btn & ~btn_q;
  assign floor_req = floor_valid(floor) ? req[floor] : 1'b0;

  lift5_dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .cnt_zero (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    door_nxt  = door_open;
    svc_nxt   = svc_floor;
    clr       = '0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (floor_req) begin
          state_nxt = ST_DWELL;
          svc_nxt   = floor;
          door_nxt  = 1'b1;
          load      = 1'b1;
        end
      end
      ST_DWELL: begin
        if (floor != svc_floor) begin
          // Car moved under an open door: drop the dwell, keep the request.
          state_nxt = ST_IDLE;
          door_nxt  = 1'b0;
        end else if (press[svc_floor]) begin
          load = 1'b1;
        end else if (cnt_zero) begin
          clr[svc_floor] = 1'b1;
          door_nxt       = 1'b0;
          state_nxt      = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        door_nxt  = 1'b0;
      end
    endcase
    // A press landing on the clearing edge wins, so the request survives.
    req_nxt = (req & ~clr) | press;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req       <= '0;
      btn_q     <= '0;
      state     <= ST_IDLE;
      door_open <= 1'b0;
      svc_floor <= '0;
    end else begin
      req       <= req_nxt;
      btn_q     <= btn;
      state     <= state_nxt;
      door_open <= door_nxt;
      svc_floor <= svc_nxt;
    end
  end

  assign ra = req[FL_A];
  assign rb = req[FL_B];
  assign rc = req[FL_C];
  assign rd = req[FL_D];
  assign re = req[FL_E];

endmodule

// File: tb/tb_lift5_req_latch.sv
// Bench for lift5_req_latch: directed scenarios plus random traffic against a
// dwell-countdown reference model.
module tb_lift5_req_latch;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [2:0] floor;
  logic       ra, rb, rc, rd, re, door_open;
  logic [2:0] svc_floor;
  logic [4:0] req_o;

  int total  = 0;
  int passed = 0;

  // Reference model: requests, remaining open-door cycles, floor in service.
  logic [4:0] m_req   = '0;
  logic [4:0] m_btnp  = '0;
  int         m_left  = 0;
  int         m_svc   = 0;

  assign req_o = {re, rd, rc, rb, ra};

  always #5 clk = ~clk;

  lift5_req_latch #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .floor     (floor),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .rd        (rd),
    .re        (re),
    .door_open (door_open),
    .svc_floor (svc_floor)
  );

  task automatic model_edge();
    logic [4:0] pr;
    logic [4:0] cl;
    if (rst) begin
      m_req = '0; m_btnp = '0; m_left = 0; m_svc = 0;
    end else begin
      pr = btn & ~m_btnp;
      cl = '0;
      if (m_left == 0) begin
        if (int'(floor) < 5 && m_req[floor]) begin
          m_left = DWELL;
          m_svc  = int'(floor);
        end
      end else if (int'(floor) != m_svc) begin
        m_left = 0;
      end else if (pr[m_svc]) begin
        m_left = DWELL;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) cl[m_svc] = 1'b1;
      end
      m_req  = (m_req & ~cl) | pr;
      m_btnp = btn;
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 5'b11111; floor = 3'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({req_o, door_open, svc_floor} !== 9'd0)
        $display("FAIL reset cyc%0d: req=%b door=%b svc=%0d, need all 0", i, req_o, door_open, svc_floor);
      else passed++;
    end
    rst = 1'b0; btn = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (req_o !== 5'b0 || door_open !== 1'b0)
        $display("FAIL reset_release cyc%0d: req=%b door=%b, need 00000/0", i, req_o, door_open);
      else passed++;
    end
  endtask

  task automatic test_latch();
    floor = 3'd0; btn = 5'b00100;
    step();
    btn = 5'b00000;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (req_o !== 5'b00100 || door_open !== 1'b0)
        $display("FAIL latch cyc%0d: req=%b door=%b, need 00100/0", i, req_o, door_open);
      else passed++;
      step();
    end
  endtask

  task automatic test_service();
    floor = 3'd2;
    for (int i = 0; i < DWELL; i++) begin
      step();
      btn = (i == 0) ? 5'b00010 : 5'b00000;
      total++;
      if (door_open !== 1'b1 || svc_floor !== 3'd2 || rc !== 1'b1)
        $display("FAIL service cyc%0d: door=%b svc=%0d rc=%b, need 1/2/1", i, door_open, svc_floor, rc);
      else passed++;
    end
    step();
    total++;
    if (door_open !== 1'b0 || rc !== 1'b0 || rb !== 1'b1)
      $display("FAIL service_end: door=%b rc=%b rb=%b, need 0/0/1", door_open, rc, rb);
    else passed++;
  endtask

  task automatic test_reopen();
    floor = 3'd2; btn = 5'b00100;
    step();                    // rc set, FSM still idle
    btn = 5'b00000;
    step();                    // enter dwell
    step();
    step();                    // one cycle of dwell left after this
    btn = 5'b00100;
    step();                    // reopen edge
    btn = 5'b00000;
    for (int i = 0; i < DWELL; i++) begin
      total++;
      if (door_open !== 1'b1 || rc !== 1'b1)
        $display("FAIL reopen cyc%0d: door=%b rc=%b, need 1/1", i, door_open, rc);
      else passed++;
      step();
    end
    total++;
    if (door_open !== 1'b0 || rc !== 1'b0)
      $display("FAIL reopen_end: door=%b rc=%b, need 0/0", door_open, rc);
    else passed++;
  endtask

  task automatic test_held();
    floor = 3'd3; btn = 5'b01000;
    step();                    // rd set
    step();                    // enter dwell
    for (int i = 0; i < DWELL - 1; i++) step();
    total++;
    if (door_open !== 1'b1 || rd !== 1'b1)
      $display("FAIL held_dwell: door=%b rd=%b, need 1/1", door_open, rd);
    else passed++;
    step();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rd !== 1'b0 || door_open !== 1'b0)
        $display("FAIL held_cleared cyc%0d: rd=%b door=%b, need 0/0", i, rd, door_open);
      else passed++;
      step();
    end
    btn = 5'b00000;
    step();
    btn = 5'b01000;
    step();
    btn = 5'b00000;
    total++;
    if (rd !== 1'b1)
      $display("FAIL held_rearm: rd=%b, need 1", rd);
    else passed++;
    for (int i = 0; i < DWELL + 2; i++) step();
    total++;
    if (rd !== 1'b0 || door_open !== 1'b0)
      $display("FAIL held_rearm_done: rd=%b door=%b, need 0/0", rd, door_open);
    else passed++;
  endtask

  task automatic test_abort();
    floor = 3'd1;              // rb still pending from service test
    step();
    step();
    total++;
    if (door_open !== 1'b1 || svc_floor !== 3'd1)
      $display("FAIL abort_enter: door=%b svc=%0d, need 1/1", door_open, svc_floor);
    else passed++;
    floor = 3'd4;
    step();
    total++;
    if (door_open !== 1'b0 || rb !== 1'b1)
      $display("FAIL abort: door=%b rb=%b, need 0/1", door_open, rb);
    else passed++;
  endtask

  task automatic test_invalid();
    floor = 3'd6; btn = 5'b11111;
    step();
    btn = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (door_open !== 1'b0 || req_o !== 5'b11111)
        $display("FAIL invalid cyc%0d: door=%b req=%b, need 0/11111", i, door_open, req_o);
      else passed++;
    end
  endtask

  task automatic test_rst_mid();
    floor = 3'd0;
    step();
    step();
    total++;
    if (door_open !== 1'b1)
      $display("FAIL rst_mid_enter: door=%b, need 1", door_open);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({req_o, door_open, svc_floor} !== 9'd0)
      $display("FAIL rst_mid: req=%b door=%b svc=%0d, need all 0", req_o, door_open, svc_floor);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 5) == 0) btn[k] = ~btn[k];
      end
      if ($urandom_range(0, 7) == 0) floor = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      step();
      total++;
      if (req_o !== m_req || door_open !== (m_left > 0) ||
          (door_open === 1'b1 && svc_floor !== 3'(m_svc)))
        $display("FAIL random cyc%0d: req=%b door=%b svc=%0d, need req=%b door=%0d svc=%0d",
                 i, req_o, door_open, svc_floor, m_req, (m_left > 0), m_svc);
      else passed++;
    end
    rst = 1'b0; btn = 5'b00000;
  endtask

  initial begin
    rst = 1'b1; btn = '0; floor = '0;
    test_reset();
    test_latch();
    test_service();
    test_reopen();
    test_held();
    test_abort();
    test_invalid();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
